// File: rtl/draw_ball_pkg.sv
// -----------------------------------------------------------------------------
// draw_ball_pkg -- shared game package.
//   Screen geometry, colour format, ball appearance defaults and the
//   constants used by the ball motion controller. Also defines the bundle
//   of VGA timing signals that travels down the pixel pipeline.
// -----------------------------------------------------------------------------
package draw_ball_pkg;

  // Visible screen area; anything beyond these lies in blanking.
  localparam int SCREEN_W = 1024;
  localparam int SCREEN_H = 768;

  // Coordinate and colour widths of the VGA timing chain (4:4:4 colour).
  localparam int COORD_W = 11;
  localparam int POS_W   = 12;
  localparam int COLOR_W = 12;

  // Ball appearance defaults.
  localparam int                 BALL_DIAMETER_DEF = 16;
  localparam logic [COLOR_W-1:0] BALL_COLOR_DEF    = 12'hFFF;

  // Ball motion controller constants.
  localparam int BALL_STEP_X    = 2;
  localparam int BALL_STEP_Y    = 2;
  localparam int BALL_X_MAX     = SCREEN_W - BALL_DIAMETER_DEF;
  localparam int BALL_Y_MAX     = SCREEN_H - BALL_DIAMETER_DEF;

  // Timing/colour bundle carried through each pipeline stage.
  typedef struct packed {
    logic [COORD_W-1:0] hcount;
    logic [COORD_W-1:0] vcount;
    logic               hsync;
    logic               vsync;
    logic               hblnk;
    logic               vblnk;
    logic [COLOR_W-1:0] rgb;
  } vga_t;

endpackage

// File: rtl/draw_ball_rom.sv
// -----------------------------------------------------------------------------
// ball_rom -- combinational 16x16 round-ball mask.
//   row  : mask row (0 = top of the bounding box)
//   mask : 16 pixels of that row, bit 15 = leftmost column
// -----------------------------------------------------------------------------
module ball_rom (
  input  logic [3:0]  row,
  output logic [15:0] mask
);

  // Row lookup of the circular ball shape.
  always_comb begin
    mask = 16'h0000;
    case (row)
      4'd0:    mask = 16'h07E0;
      4'd1:    mask = 16'h1FF8;
      4'd2:    mask = 16'h3FFC;
      4'd3:    mask = 16'h7FFE;
      4'd4:    mask = 16'h7FFE;
      4'd5:    mask = 16'hFFFF;
      4'd6:    mask = 16'hFFFF;
      4'd7:    mask = 16'hFFFF;
      4'd8:    mask = 16'hFFFF;
      4'd9:    mask = 16'hFFFF;
      4'd10:   mask = 16'hFFFF;
      4'd11:   mask = 16'h7FFE;
      4'd12:   mask = 16'h7FFE;
      4'd13:   mask = 16'h3FFC;
      4'd14:   mask = 16'h1FF8;
      4'd15:   mask = 16'h07E0;
      default: mask = 16'h0000;
    endcase
  end

endmodule

// File: rtl/draw_ball.sv
// -----------------------------------------------------------------------------
// draw_ball -- overlays a round ball on the VGA pixel stream.
//   Two-stage pipeline: stage 1 tests the pixel against the ball bounding box,
//   stage 2 applies the round mask and composites the colour. All timing
//   signals are delayed by exactly two pclk cycles.
// Ports:
//   pclk, rst                     pixel clock, synchronous active-high reset
//   hcount_in, vcount_in (11b)    pixel coordinates from the timing chain
//   hsync_in, vsync_in,
//   hblnk_in, vblnk_in            sync/blanking from the timing chain
//   rgb_in (12b)                  background colour
//   xpos, ypos (12b)              ball top-left corner, sampled once per frame
//   *_out                         the same signals, 2 cycles later, with the
//                                 ball composited into rgb_out
// -----------------------------------------------------------------------------
module draw_ball
  import draw_ball_pkg::*;
#(
  parameter int                 BALL_DIAMETER = BALL_DIAMETER_DEF,
  parameter logic [COLOR_W-1:0] BALL_COLOR    = BALL_COLOR_DEF
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic [COORD_W-1:0] hcount_in,
  input  logic [COORD_W-1:0] vcount_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               hblnk_in,
  input  logic               vblnk_in,
  input  logic [COLOR_W-1:0] rgb_in,
  input  logic [POS_W-1:0]   xpos,
  input  logic [POS_W-1:0]   ypos,
  output logic [COORD_W-1:0] hcount_out,
  output logic [COORD_W-1:0] vcount_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               hblnk_out,
  output logic               vblnk_out,
  output logic [COLOR_W-1:0] rgb_out
);

  localparam logic [12:0] DIAM13 = 13'(BALL_DIAMETER);

  // Frame-stable ball position and vblnk edge detector.
  logic             vblnk_prev_r;
  logic [POS_W-1:0] x_lat_r;
  logic [POS_W-1:0] y_lat_r;
  logic             vblnk_rise_s;

  // Stage 1 results.
  vga_t        s1_vga_r;
  logic        s1_in_box_r;
  logic [3:0]  s1_row_r;
  logic [3:0]  s1_col_r;

  // Stage 1 combinational terms.
  logic [12:0] h_ext_s;
  logic [12:0] v_ext_s;
  logic [12:0] x_lo_s;
  logic [12:0] y_lo_s;
  logic [12:0] x_hi_s;
  logic [12:0] y_hi_s;
  logic        in_box_s;
  logic [3:0]  row_s;
  logic [3:0]  col_s;

  // Stage 2 combinational terms.
  logic [15:0] mask_s;
  logic [3:0]  bit_idx_s;
  logic        is_ball_s;

  assign vblnk_rise_s = vblnk_in & ~vblnk_prev_r;

  // Latch the ball position only at the start of vertical blanking so a
  // position change never tears the ball within a visible frame.
  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_prev_r <= 1'b0;
      x_lat_r      <= '0;
      y_lat_r      <= '0;
    end else begin
      vblnk_prev_r <= vblnk_in;
      if (vblnk_rise_s) begin
        x_lat_r <= xpos;
        y_lat_r <= ypos;
      end
    end
  end

  // Bounding-box test. Everything is widened to 13 bits so x_lat + diameter
  // cannot wrap, which keeps the box from reappearing at hcount/vcount 0.
  // Only the low 4 bits of the offsets are needed, and those equal the
  // difference of the low 4 bits of the operands.
  always_comb begin
    h_ext_s  = {2'b00, hcount_in};
    v_ext_s  = {2'b00, vcount_in};
    x_lo_s   = {1'b0, x_lat_r};
    y_lo_s   = {1'b0, y_lat_r};
    x_hi_s   = x_lo_s + DIAM13;
    y_hi_s   = y_lo_s + DIAM13;
    in_box_s = (h_ext_s >= x_lo_s) && (h_ext_s < x_hi_s) &&
               (v_ext_s >= y_lo_s) && (v_ext_s < y_hi_s);
    row_s    = vcount_in[3:0] - y_lat_r[3:0];
    col_s    = hcount_in[3:0] - x_lat_r[3:0];
  end

  // Stage 1 register: timing bundle plus box hit and offsets.
  always_ff @(posedge pclk) begin
    if (rst) begin
      s1_vga_r    <= '0;
      s1_in_box_r <= 1'b0;
      s1_row_r    <= 4'd0;
      s1_col_r    <= 4'd0;
    end else begin
      s1_vga_r    <= '{hcount: hcount_in, vcount: vcount_in,
                       hsync: hsync_in, vsync: vsync_in,
                       hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};
      s1_in_box_r <= in_box_s;
      s1_row_r    <= row_s;
      s1_col_r    <= col_s;
    end
  end

  ball_rom u_ball_rom (
    .row  (s1_row_r),
    .mask (mask_s)
  );

  // Mask lookup; blanking always wins so off-screen parts of the box vanish.
  always_comb begin
    bit_idx_s = 4'd15 - s1_col_r;
    is_ball_s = s1_in_box_r & mask_s[bit_idx_s] &
                ~s1_vga_r.hblnk & ~s1_vga_r.vblnk;
  end

  // Stage 2 register: outputs.
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= s1_vga_r.hcount;
      vcount_out <= s1_vga_r.vcount;
      hsync_out  <= s1_vga_r.hsync;
      vsync_out  <= s1_vga_r.vsync;
      hblnk_out  <= s1_vga_r.hblnk;
      vblnk_out  <= s1_vga_r.vblnk;
      rgb_out    <= is_ball_s ? BALL_COLOR : s1_vga_r.rgb;
    end
  end

endmodule

// File: tb/tb_draw_ball.sv
module tb_draw_ball;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in, xpos, ypos;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  draw_ball dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  typedef struct {
    bit          rst;
    logic [10:0] h, v;
    bit          hs, vs, hb, vb;
    logic [11:0] rgb, x, y;
  } in_t;

  typedef struct {
    logic [10:0] h, v;
    bit          hs, vs, hb, vb;
    logic [11:0] rgb;
  } out_t;

  typedef struct {
    in_t         in;
    bit          chk;
    logic [11:0] exp_rgb;
    string       name;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: ball shape, position as seen by the drawing,
  // last vblnk sample, and the expected outputs in flight.
  logic [15:0] mask_tbl [16];
  int          m_xl, m_yl;
  bit          m_vprev;
  out_t        m_pipe0, m_pipe1;

  function automatic out_t zero_out();
    out_t o;
    o.h = 11'd0; o.v = 11'd0; o.hs = 1'b0; o.vs = 1'b0;
    o.hb = 1'b0; o.vb = 1'b0; o.rgb = 12'h000;
    return o;
  endfunction

  function automatic in_t mk_in(input bit r, input logic [10:0] h, input logic [10:0] v,
                                input bit hb, input bit vb, input logic [11:0] rgb,
                                input logic [11:0] x, input logic [11:0] y);
    in_t t;
    t.rst = r; t.h = h; t.v = v; t.hs = h[3]; t.vs = v[2];
    t.hb = hb; t.vb = vb; t.rgb = rgb; t.x = x; t.y = y;
    return t;
  endfunction

  function automatic vec_t mkv(input in_t i, input bit chk, input logic [11:0] e, input string n);
    vec_t r;
    r.in = i; r.chk = chk; r.exp_rgb = e; r.name = n;
    return r;
  endfunction

  // What the screen should show for one input pixel, from plain geometry.
  function automatic out_t ref_pix(input in_t v, input int xl, input int yl);
    out_t o;
    int   dx, dy;
    bit   ball;
    dx = int'(v.h) - xl;
    dy = int'(v.v) - yl;
    ball = 1'b0;
    if (dx >= 0 && dx < 16 && dy >= 0 && dy < 16) ball = mask_tbl[dy][15 - dx];
    o.h = v.h; o.v = v.v; o.hs = v.hs; o.vs = v.vs; o.hb = v.hb; o.vb = v.vb;
    o.rgb = (ball && !v.hb && !v.vb) ? 12'hFFF : v.rgb;
    return o;
  endfunction

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input in_t v);
    if (v.rst) begin
      m_pipe0 = zero_out();
      m_pipe1 = zero_out();
      m_xl = 0; m_yl = 0; m_vprev = 1'b0;
    end else begin
      m_pipe1 = m_pipe0;
      m_pipe0 = ref_pix(v, m_xl, m_yl);
      if (v.vb && !m_vprev) begin
        m_xl = int'(v.x);
        m_yl = int'(v.y);
      end
      m_vprev = v.vb;
    end
  endtask

  task automatic check_model();
    cmp("hcount_out", 16'(hcount_out), 16'(m_pipe1.h));
    cmp("vcount_out", 16'(vcount_out), 16'(m_pipe1.v));
    cmp("hsync_out",  16'(hsync_out),  16'(m_pipe1.hs));
    cmp("vsync_out",  16'(vsync_out),  16'(m_pipe1.vs));
    cmp("hblnk_out",  16'(hblnk_out),  16'(m_pipe1.hb));
    cmp("vblnk_out",  16'(vblnk_out),  16'(m_pipe1.vb));
    cmp("rgb_out",    16'(rgb_out),    16'(m_pipe1.rgb));
  endtask

  // Drive one pixel, clock it in, then check every output against the model.
  task automatic apply(input in_t v);
    rst = v.rst; hcount_in = v.h; vcount_in = v.v;
    hsync_in = v.hs; vsync_in = v.vs; hblnk_in = v.hb; vblnk_in = v.vb;
    rgb_in = v.rgb; xpos = v.x; ypos = v.y;
    @(posedge pclk);
    model_edge(v);
    #1;
    check_model();
  endtask

  task automatic latch(input logic [11:0] x, input logic [11:0] y);
    apply(mk_in(1'b0, 11'd0, 11'd770, 1'b1, 1'b0, 12'h000, x, y));
    apply(mk_in(1'b0, 11'd0, 11'd770, 1'b1, 1'b1, 12'h000, x, y));
    apply(mk_in(1'b0, 11'd0, 11'd0,   1'b1, 1'b0, 12'h000, x, y));
  endtask

  // One pixel followed by an idle pixel; rgb_out then shows the first pixel.
  task automatic pix(input string name, input logic [10:0] h, input logic [10:0] v,
                     input bit hb, input logic [11:0] rgb, input logic [11:0] x,
                     input logic [11:0] y, input logic [11:0] exp);
    apply(mk_in(1'b0, h, v, hb, 1'b0, rgb, x, y));
    apply(mk_in(1'b0, 11'd2047, 11'd2047, 1'b1, 1'b0, 12'h000, x, y));
    cmp(name, 16'(rgb_out), 16'(exp));
  endtask

  vec_t tbl [16];
  in_t  prev;

  initial begin
    mask_tbl = '{16'h07E0, 16'h1FF8, 16'h3FFC, 16'h7FFE, 16'h7FFE, 16'hFFFF,
                 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7FFE,
                 16'h7FFE, 16'h3FFC, 16'h1FF8, 16'h07E0};
    m_xl = 0; m_yl = 0; m_vprev = 1'b0;
    m_pipe0 = zero_out(); m_pipe1 = zero_out();

    // Reset state.
    apply(mk_in(1'b1, 11'd77, 11'd55, 1'b1, 1'b1, 12'hABC, 12'd5, 12'd6));
    cmp("reset_rgb", 16'(rgb_out), 16'h0000);
    cmp("reset_hcount", 16'(hcount_out), 16'h0000);
    cmp("reset_vblnk", 16'(vblnk_out), 16'h0000);

    // Directed vectors: each expected rgb appears one apply later.
    tbl[0]  = mkv(mk_in(0, 11'd0,    11'd0,   0, 0, 12'h000, 12'd100,  12'd200), 0, 12'h000, "pre");
    tbl[1]  = mkv(mk_in(0, 11'd0,    11'd770, 0, 1, 12'h000, 12'd100,  12'd200), 0, 12'h000, "latch_100_200");
    tbl[2]  = mkv(mk_in(0, 11'd108,  11'd208, 0, 0, 12'h000, 12'd100,  12'd200), 1, 12'hFFF, "hit_centre");
    tbl[3]  = mkv(mk_in(0, 11'd100,  11'd200, 0, 0, 12'h000, 12'd100,  12'd200), 1, 12'h000, "corner_masked");
    tbl[4]  = mkv(mk_in(0, 11'd105,  11'd200, 0, 0, 12'h000, 12'd100,  12'd200), 1, 12'hFFF, "top_row_hit");
    tbl[5]  = mkv(mk_in(0, 11'd108,  11'd208, 1, 0, 12'h0AB, 12'd100,  12'd200), 1, 12'h0AB, "hblnk_hides");
    tbl[6]  = mkv(mk_in(0, 11'd116,  11'd208, 0, 0, 12'h123, 12'd100,  12'd200), 1, 12'h123, "right_of_box");
    tbl[7]  = mkv(mk_in(0, 11'd108,  11'd208, 0, 0, 12'h000, 12'd300,  12'd200), 1, 12'hFFF, "xpos_change_ignored");
    tbl[8]  = mkv(mk_in(0, 11'd0,    11'd0,   0, 0, 12'h000, 12'd1020, 12'd10),  0, 12'h000, "pre_edge");
    tbl[9]  = mkv(mk_in(0, 11'd0,    11'd770, 0, 1, 12'h000, 12'd1020, 12'd10),  0, 12'h000, "latch_1020_10");
    tbl[10] = mkv(mk_in(0, 11'd1023, 11'd17,  0, 0, 12'h000, 12'd1020, 12'd10),  1, 12'hFFF, "edge_last_col");
    tbl[11] = mkv(mk_in(0, 11'd0,    11'd17,  0, 0, 12'h0F0, 12'd1020, 12'd10),  1, 12'h0F0, "edge_no_wrap_h0");
    tbl[12] = mkv(mk_in(0, 11'd1020, 11'd15,  0, 0, 12'h000, 12'd1020, 12'd10),  1, 12'hFFF, "edge_first_col");
    tbl[13] = mkv(mk_in(0, 11'd3,    11'd15,  0, 0, 12'h5A5, 12'd1020, 12'd10),  1, 12'h5A5, "edge_no_wrap_h3");
    tbl[14] = mkv(mk_in(0, 11'd1021, 11'd10,  0, 0, 12'h111, 12'd1020, 12'd10),  1, 12'h111, "edge_corner_masked");
    tbl[15] = mkv(mk_in(0, 11'd2047, 11'd2047,1, 0, 12'h000, 12'd1020, 12'd10),  0, 12'h000, "pad");
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].in);
      if (i >= 1 && tbl[i-1].chk) cmp(tbl[i-1].name, 16'(rgb_out), 16'(tbl[i-1].exp_rgb));
    end

    // Tear-free update and same-cycle latch.
    latch(12'd100, 12'd300);
    pix("tear_old_x_kept", 11'd108, 11'd305, 1'b0, 12'h000, 12'd300, 12'd300, 12'hFFF);
    pix("tear_new_x_not_yet", 11'd308, 11'd305, 1'b0, 12'h00F, 12'd300, 12'd300, 12'h00F);
    latch(12'd300, 12'd300);
    pix("tear_new_x", 11'd308, 11'd305, 1'b0, 12'h000, 12'd300, 12'd300, 12'hFFF);
    pix("tear_old_x_gone", 11'd108, 11'd305, 1'b0, 12'h0F0, 12'd300, 12'd300, 12'h0F0);
    apply(mk_in(1'b0, 11'd0, 11'd770, 1'b1, 1'b0, 12'h000, 12'd500, 12'd300));
    apply(mk_in(1'b0, 11'd0, 11'd770, 1'b1, 1'b1, 12'h000, 12'd700, 12'd300));
    apply(mk_in(1'b0, 11'd0, 11'd0,   1'b1, 1'b0, 12'h000, 12'd900, 12'd300));
    pix("same_cycle_latch", 11'd708, 11'd308, 1'b0, 12'h000, 12'd900, 12'd300, 12'hFFF);

    // Reset mid-frame.
    latch(12'd100, 12'd200);
    apply(mk_in(1'b1, 11'd50, 11'd400, 1'b0, 1'b0, 12'hABC, 12'd100, 12'd200));
    cmp("midrst_rgb", 16'(rgb_out), 16'h0000);
    cmp("midrst_vcount", 16'(vcount_out), 16'h0000);
    cmp("midrst_hsync", 16'(hsync_out), 16'h0000);
    pix("post_rst_ball_origin", 11'd8, 11'd8, 1'b0, 12'h000, 12'd100, 12'd200, 12'hFFF);
    pix("post_rst_old_pos_gone", 11'd108, 11'd208, 1'b0, 12'h00A, 12'd100, 12'd200, 12'h00A);
    latch(12'd100, 12'd200);
    pix("post_rst_relatched", 11'd108, 11'd208, 1'b0, 12'h000, 12'd100, 12'd200, 12'hFFF);

    // Pass-through with the ball parked off-screen.
    latch(12'd900, 12'd900);
    prev = mk_in(1'b0, 11'd0, 11'd0, 1'b1, 1'b0, 12'h000, 12'd900, 12'd900);
    for (int i = 0; i < 400; i++) begin
      in_t t;
      t = mk_in(1'b0, 11'($urandom_range(0, 899)), 11'($urandom),
                1'($urandom), 1'($urandom), 12'($urandom), 12'd900, 12'd900);
      t.hs = 1'($urandom); t.vs = 1'($urandom);
      apply(t);
      cmp("pass_rgb", 16'(rgb_out), 16'(prev.rgb));
      cmp("pass_hcount", 16'(hcount_out), 16'(prev.h));
      prev = t;
    end

    // Random traffic around the ball with position changes, vblnk edges and resets.
    begin
      bit          vb = 1'b0;
      logic [11:0] rx = 12'd100;
      logic [11:0] ry = 12'd100;
      for (int i = 0; i < 2500; i++) begin
        in_t t;
        int  hh, vv;
        if ($urandom_range(0, 39) == 0) vb = ~vb;
        if ($urandom_range(0, 7) == 0) begin
          rx = 12'($urandom_range(0, 1100));
          ry = 12'($urandom_range(0, 1100));
        end
        hh = m_xl - 2 + int'($urandom_range(0, 20));
        vv = m_yl - 2 + int'($urandom_range(0, 20));
        t = mk_in(($urandom_range(0, 399) == 0), 11'(hh), 11'(vv),
                  ($urandom_range(0, 7) == 0), vb, 12'($urandom), rx, ry);
        apply(t);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_ball.md
DRAW_BALL -- requirements
Module: draw_ball

Interface
REQ-001 pclk  input  1  pixel clock; all logic on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 hcount_in, vcount_in  input  11 each  pixel coordinates from the upstream VGA timing chain.
REQ-004 hsync_in, vsync_in, hblnk_in, vblnk_in  input  1 each  sync and blanking from upstream.
REQ-005 rgb_in  input  12  background colour, 4:4:4.
REQ-006 xpos, ypos  input  12 each  ball top-left corner from the ball motion controller; may change on any cycle.
REQ-007 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out  output  same widths as the inputs  delayed timing and composited colour.
REQ-008 Parameter BALL_DIAMETER, default 16: ball bounding-box side in pixels.
REQ-009 Parameter BALL_COLOR, default 12'hFFF: ball pixel colour.

Function
REQ-010 Fixed latency SHALL be exactly 2 pclk cycles from every input to every corresponding output, with no bubbles.
REQ-011 Timing outputs SHALL equal their inputs delayed by 2 cycles, bit-exact.
REQ-012 The block SHALL hold shadow registers x_lat and y_lat (12 bit each), loaded from xpos and ypos only on the cycle a rising edge of vblnk_in is detected (vblnk_in=1, previous sample=0).
REQ-013 xpos and ypos changes outside that edge SHALL NOT affect drawing until the next rising edge, so the ball never tears within a frame.
REQ-014 Stage 1 SHALL compute in_box = (hcount_in >= x_lat) && (hcount_in < x_lat + BALL_DIAMETER) && (vcount_in >= y_lat) && (vcount_in < y_lat + BALL_DIAMETER).
REQ-015 Stage 1 sums SHALL be computed 13 bits wide, zero-extended, so the comparison never wraps.
REQ-016 Stage 1 SHALL register in_box, row = vcount_in - y_lat (4 bit) and col = hcount_in - x_lat (4 bit).
REQ-017 Stage 2 SHALL read the 16-bit mask for row; pixel is ball when in_box && mask[15-col] && !hblnk && !vblnk, with the blanking flags taken from the stage-1-delayed copies.
REQ-018 Mask rows 0..15 SHALL be: 07E0, 1FF8, 3FFC, 7FFE, 7FFE, FFFF x6, 7FFE, 7FFE, 3FFC, 1FF8, 07E0 (hex).
REQ-019 rgb_out SHALL be BALL_COLOR when the pixel is ball, else rgb_in delayed by 2 cycles.
REQ-020 Boundary: box parts beyond hcount 1023 or vcount 767 fall in blanking and SHALL NOT be drawn.
REQ-021 Boundary: the box SHALL NOT wrap to hcount 0 or vcount 0.
REQ-022 Boundary: if a vblnk rising edge and an xpos change occur on the same cycle, the value present on that cycle SHALL be latched.

Reset
REQ-023 While rst=1, all outputs, both pipeline stages, x_lat, y_lat and the vblnk edge register SHALL be 0 on the next pclk edge.
REQ-024 Reset mid-frame SHALL have the same effect as REQ-023; normal operation resumes the cycle after rst falls, and the ball stays at (0,0) until the next vblnk rising edge.

Structure
REQ-025 BALL_DIAMETER, BALL_COLOR, screen size 1024x768 and the 4:4:4 colour width SHALL live in the shared game package, alongside the constants used by the ball motion controller.
REQ-026 The mask table SHALL be a combinational sub-module ball_rom (input row 4 bit, output mask 16 bit), instantiated once in stage 2.

Verification
REQ-027 Pass-through: xpos=ypos=900 latched, random timing -> all outputs equal inputs delayed by exactly 2 cycles; rgb_out = rgb_in.
REQ-028 Hit: latch (100,200), rgb_in=12'h000:
- pixel (108,208) -> rgb_out=12'hFFF two cycles later.
- pixel (100,200) -> 12'h000 (corner masked).
- pixel (105,200) -> 12'hFFF.
REQ-029 Tear-free update: change xpos from 100 to 300 at vcount=300 -> rest of frame drawn at x=100; x=300 used only after the next vblnk rising edge.
REQ-030 Edge: latch x=1020, y=10 -> hcount 1020..1023 drawn per mask; hcount 0..3 on rows 10..25 -> rgb_in (no wrap).
REQ-031 Blanking: in_box pixel with hblnk_in=1 -> rgb_out = rgb_in.
REQ-032 Reset mid-frame: rst=1 for 1 cycle at vcount=400 -> all outputs 0 next cycle; ball at (0,0) until the next vblnk rising edge.
